// File: rtl/fetch_if.sv
// Fetch port bundle: branch/stall control from the pipeline, the req/ready
// instruction-memory port, and the IF/ID presentation signals.
// The fetch controller uses the master modport (it masters the imem request
// and drives IF/ID); the surrounding pipeline and memory use slave.
`timescale 1ns/1ps
interface fetch_if #(
    parameter int ADDR_W = 32
) ();
    logic              Br_taken;
    logic [ADDR_W-1:0] Br_offset;
    logic              stall;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [31:0]       imem_rdata;
    logic [ADDR_W-1:0] PC;
    logic [31:0]       Instruction;
    logic              inst_valid;
    logic              fetch_timeout;

    modport master (
        input  Br_taken, Br_offset, stall, imem_ready, imem_rdata,
        output imem_req, imem_addr, PC, Instruction, inst_valid, fetch_timeout
    );

    modport slave (
        output Br_taken, Br_offset, stall, imem_ready, imem_rdata,
        input  imem_req, imem_addr, PC, Instruction, inst_valid, fetch_timeout
    );
endinterface

// File: rtl/fetch_controller.sv
// IF-stage fetch sequencer. Owns the fetch PC, issues one outstanding request
// at a time to a variable-latency instruction memory, and presents PC /
// Instruction / inst_valid to the IF/ID register. A one-entry buffer absorbs
// the word that returns while IF/ID is stalled; branch redirects squash
// in-flight and buffered words; a stuck memory parks the block in ERR.
`timescale 1ns/1ps
module fetch_controller #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MAX_WAIT = 15
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);

    localparam int                WAIT_W     = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              redirect_pend;
    logic              timeout_q;

    // fetch side: address being requested plus the parked words
    logic [ADDR_W-1:0] fetch_pc_p0;
    logic [ADDR_W-1:0] pend_pc_p0;
    logic [ADDR_W-1:0] buf_pc_p0;
    logic [31:0]       buf_inst_p0;

    // IF/ID presentation register
    logic [ADDR_W-1:0] pc_p1;
    logic [31:0]       inst_p1;
    logic              vld_p1;

    logic in_fetch;
    logic buf_load;
    logic pend_load;

    // Sequential PC step; wraps silently from all-ones to zero.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction

    assign in_fetch  = (state == FETCH);
    // Word returns while IF/ID holds a valid stalled instruction: park it.
    assign buf_load  = in_fetch && bus.imem_ready && !bus.Br_taken && !redirect_pend
                       && bus.stall && vld_p1;
    // Redirect while the request is still outstanding: remember the target.
    assign pend_load = in_fetch && !bus.imem_ready && bus.Br_taken;

    // Data-only capture of the parked word and the deferred redirect target.
    always_ff @(posedge clk) begin
        if (buf_load) begin
            buf_pc_p0   <= fetch_pc_p0;
            buf_inst_p0 <= bus.imem_rdata;
        end
        if (pend_load) begin
            pend_pc_p0 <= bus.Br_offset;
        end
    end

    // Fetch FSM: request sequencing, redirect, timeout and IF/ID outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            fetch_pc_p0   <= RESET_PC;
            pc_p1         <= '0;
            inst_p1       <= '0;
            vld_p1        <= 1'b0;
            timeout_q     <= 1'b0;
            redirect_pend <= 1'b0;
            wait_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    if (bus.Br_taken) begin
                        fetch_pc_p0 <= bus.Br_offset;
                    end
                    if (bus.Br_taken || !bus.stall) begin
                        vld_p1 <= 1'b0;
                    end
                end

                FETCH: begin
                    if (bus.imem_ready) begin
                        wait_cnt <= '0;
                        if (bus.Br_taken) begin
                            // returning word belongs to the squashed path
                            fetch_pc_p0   <= bus.Br_offset;
                            redirect_pend <= 1'b0;
                            vld_p1        <= 1'b0;
                        end else if (redirect_pend) begin
                            fetch_pc_p0   <= pend_pc_p0;
                            redirect_pend <= 1'b0;
                            if (!bus.stall) begin
                                vld_p1 <= 1'b0;
                            end
                        end else if (!bus.stall || !vld_p1) begin
                            pc_p1       <= fetch_pc_p0;
                            inst_p1     <= bus.imem_rdata;
                            vld_p1      <= 1'b1;
                            fetch_pc_p0 <= pc_inc(fetch_pc_p0);
                        end else begin
                            fetch_pc_p0 <= pc_inc(fetch_pc_p0);
                            state       <= HOLD;
                        end
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        wait_cnt      <= '0;
                        redirect_pend <= 1'b0;
                        vld_p1        <= 1'b0;
                        timeout_q     <= 1'b1;
                        state         <= ERR;
                    end else begin
                        // address must stay put; a redirect is only recorded
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                        if (bus.Br_taken) begin
                            redirect_pend <= 1'b1;
                            vld_p1        <= 1'b0;
                        end else if (!bus.stall) begin
                            vld_p1 <= 1'b0;
                        end
                    end
                end

                HOLD: begin
                    if (bus.Br_taken) begin
                        fetch_pc_p0 <= bus.Br_offset;
                        vld_p1      <= 1'b0;
                        state       <= FETCH;
                    end else if (!bus.stall) begin
                        pc_p1   <= buf_pc_p0;
                        inst_p1 <= buf_inst_p0;
                        vld_p1  <= 1'b1;
                        state   <= FETCH;
                    end
                end

                ERR: begin
                    vld_p1    <= 1'b0;
                    timeout_q <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.imem_req      = in_fetch;
    assign bus.imem_addr     = fetch_pc_p0;
    assign bus.PC            = pc_p1;
    assign bus.Instruction   = inst_p1;
    assign bus.inst_valid    = vld_p1;
    assign bus.fetch_timeout = timeout_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: a random-latency imem responder, randomized
// stall/branch traffic, and a scoreboard that predicts the instruction stream
// IF/ID must accept (consecutive addresses, restarting at each branch target).
`timescale 1ns/1ps
module tb_fetch_controller;

    localparam int          ADDR_W   = 32;
    localparam int          MAX_WAIT = 15;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_if #(.ADDR_W(ADDR_W)) bus ();

    fetch_controller #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Instruction memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // ---------------- imem responder ----------------
    bit mute    = 1'b0;
    int min_lat = 0;
    int max_lat = 0;
    bit rsp_active = 1'b0;
    int rsp_cnt    = 0;
    bit hs_seen    = 1'b0;

    // Note whether a req/ready handshake will complete on the coming edge.
    always @(negedge clk) hs_seen = bus.imem_req && bus.imem_ready;

    // Answer each request after a random number of wait cycles.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            rsp_active     = 1'b0;
            bus.imem_ready = 1'b0;
        end else begin
            if (hs_seen || !bus.imem_req) rsp_active = 1'b0;
            if (!rsp_active && bus.imem_req) begin
                rsp_active = 1'b1;
                rsp_cnt    = $urandom_range(min_lat, max_lat);
            end
            if (rsp_active && !mute && rsp_cnt == 0) begin
                bus.imem_ready = 1'b1;
                bus.imem_rdata = mem_word(bus.imem_addr);
            end else begin
                bus.imem_ready = 1'b0;
                bus.imem_rdata = $urandom;
                if (rsp_active && rsp_cnt > 0) rsp_cnt--;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [ADDR_W-1:0] seg_q[$];      // branch targets, pushed as branches are issued
    logic [ADDR_W-1:0] exp_pc;
    logic [ADDR_W-1:0] prev_addr;
    bit                prev_wait = 1'b0;
    int                consumed  = 0;

    // Any reset restarts the expected stream at RESET_PC.
    always @(negedge rst) begin
        exp_pc    = RESET_PC;
        prev_wait = 1'b0;
    end

    // Compare every instruction IF/ID accepts against the predicted stream.
    always @(negedge clk) begin
        if (rst) begin
            if (prev_wait && bus.imem_req) check("imem_addr_stable", bus.imem_addr, prev_addr);
            prev_wait = bus.imem_req && !bus.imem_ready;
            prev_addr = bus.imem_addr;
            if (bus.inst_valid && !bus.stall) begin
                check("accepted_pc", bus.PC, exp_pc);
                check("accepted_inst", bus.Instruction, mem_word(exp_pc));
                exp_pc = exp_pc + 1;
                consumed++;
            end
            if (bus.Br_taken) begin
                check("branch_target_queued", seg_q.size() > 0, 1'b1);
                if (seg_q.size() > 0) exp_pc = seg_q.pop_front();
            end
        end
    end

    // ---------------- stimulus ----------------
    int  vld_count;
    int  req_cycles;
    bit  found;
    bit  to_seen;

    initial begin
        bus.Br_taken   = 1'b0;
        bus.Br_offset  = '0;
        bus.stall      = 1'b0;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = '0;

        // asynchronous reset values
        #1 rst = 1'b0;
        #1;
        check("rst_imem_req", bus.imem_req, 1'b0);
        check("rst_inst_valid", bus.inst_valid, 1'b0);
        check("rst_PC", bus.PC, 32'h0);
        check("rst_Instruction", bus.Instruction, 32'h0);
        check("rst_fetch_timeout", bus.fetch_timeout, 1'b0);

        // zero-latency memory: first valid on the 2nd cycle after IDLE, then PC 0,1,2,3
        min_lat = 0;
        max_lat = 0;
        #20 rst = 1'b1;
        @(negedge clk);
        check("t1_first_cycle_valid", bus.inst_valid, 1'b0);
        check("t1_first_cycle_req", bus.imem_req, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_valid", bus.inst_valid, 1'b1);
            check("t1_pc", bus.PC, 32'(i));
        end

        // three wait cycles per word: exactly one valid every four cycles
        min_lat = 3;
        max_lat = 3;
        repeat (8) @(negedge clk);
        vld_count = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.inst_valid) vld_count++;
        end
        check("t2_valid_1_of_4", vld_count, 4);

        // randomized stall / branch / latency traffic
        min_lat = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 500 == 0) max_lat = $urandom_range(0, 6);
            @(posedge clk);
            #1;
            bus.stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) begin
                bus.Br_taken = 1'b1;
                case ($urandom_range(0, 3))
                    0:       bus.Br_offset = 32'h40;
                    1:       bus.Br_offset = 32'hFFFF_FFFE;
                    default: bus.Br_offset = $urandom;
                endcase
                seg_q.push_back(bus.Br_offset);
            end else begin
                bus.Br_taken  = 1'b0;
                bus.Br_offset = $urandom;
            end
        end
        @(posedge clk);
        #1;
        bus.Br_taken = 1'b0;
        bus.stall    = 1'b0;
        repeat (20) @(negedge clk);
        check("random_progress", consumed > 300, 1'b1);

        // wrap: the request after all-ones goes to address zero
        min_lat = 0;
        max_lat = 0;
        @(posedge clk);
        #1;
        bus.Br_taken  = 1'b1;
        bus.Br_offset = 32'hFFFF_FFFF;
        seg_q.push_back(bus.Br_offset);
        @(posedge clk);
        #1;
        bus.Br_taken = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_ready && bus.imem_addr == 32'hFFFF_FFFF) begin
                found = 1'b1;
                break;
            end
        end
        check("wrap_fetch_seen", found, 1'b1);
        @(negedge clk);
        check("wrap_next_addr", bus.imem_addr, 32'h0);
        check("wrap_next_req", bus.imem_req, 1'b1);

        // memory never answers: timeout after MAX_WAIT+1 waiting cycles
        @(negedge clk);
        #2 rst = 1'b0;
        seg_q.delete();
        mute = 1'b1;
        #5 rst = 1'b1;
        req_cycles = 0;
        to_seen    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.fetch_timeout) begin
                to_seen = 1'b1;
                break;
            end
            if (bus.imem_req) req_cycles++;
        end
        check("timeout_raised", to_seen, 1'b1);
        check("timeout_wait_cycles", req_cycles, MAX_WAIT + 1);
        check("timeout_req_low", bus.imem_req, 1'b0);
        check("timeout_valid_low", bus.inst_valid, 1'b0);
        mute = 1'b0;
        repeat (3) @(negedge clk);
        check("timeout_sticky", bus.fetch_timeout, 1'b1);
        check("timeout_req_stays_low", bus.imem_req, 1'b0);

        // asynchronous reset in the middle of an outstanding request
        #2 rst = 1'b0;
        seg_q.delete();
        #5 rst = 1'b1;
        repeat (8) @(negedge clk);
        mute = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_pre_pc_nonzero", bus.PC != 32'h0, 1'b1);
        check("midreset_pre_req", bus.imem_req, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("midreset_req", bus.imem_req, 1'b0);
        check("midreset_PC", bus.PC, 32'h0);
        check("midreset_Instruction", bus.Instruction, 32'h0);
        check("midreset_valid", bus.inst_valid, 1'b0);
        check("midreset_timeout", bus.fetch_timeout, 1'b0);
        mute = 1'b0;
        #4 rst = 1'b1;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
